// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS controller and ALU.
package mips_ctrl_pkg;
    typedef enum logic [2:0] {
        NOTHING = 3'd0,
        ADD     = 3'd1,
        SUB     = 3'd2,
        AND     = 3'd3,
        OR      = 3'd4,
        SLT     = 3'd5
    } alu_op_t;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
        MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps opcode/funct to the ALU operation and flags unsupported encodings.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);
    always_comb begin
        alu_op = NOTHING;
        valid  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ADD;
                    FN_SUB:  alu_op = SUB;
                    FN_AND:  alu_op = AND;
                    FN_OR:   alu_op = OR;
                    FN_SLT:  alu_op = SLT;
                    default: valid  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: alu_op = ADD;
            OP_SLTI:               alu_op = SLT;
            OP_BEQ:                alu_op = SUB;
            OP_J:                  alu_op = NOTHING;
            default:               valid  = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: main FSM of the multi-cycle MIPS datapath with memory-wait watchdog.
// Define MC_CTRL_PERF_EN to add the retired_cnt/cycle_cnt performance counters.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_operation,
    output logic       illegal_op,
    output logic       mem_timeout
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] cycle_cnt
`endif
);
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

    state_t     r_state, w_next;
    logic [3:0] r_wait;
    logic [2:0] w_alu_op;
    logic       w_valid, w_stall, w_expire;

    mips_alu_decoder u_dec (
        .opcode(opcode),
        .funct (funct),
        .alu_op(w_alu_op),
        .valid (w_valid)
    );

    assign w_stall  = (r_state == FETCH || r_state == MEM_RD || r_state == MEM_WR) && !mem_ready;
    assign w_expire = (MEM_WAIT_MAX != 0) && w_stall && (r_wait == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_wait      <= (w_stall && !w_expire) ? r_wait + 4'd1 : 4'd0;
            mem_timeout <= mem_timeout | w_expire;
        end
    end

    always_comb begin
        w_next        = r_state;
        pc_en         = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        pc_src        = PCSRC_ALU;
        alu_operation = NOTHING;
        illegal_op    = 1'b0;
        case (r_state)
            IDLE: w_next = FETCH;
            FETCH: begin
                mem_read      = 1'b1;
                alu_src_b     = SRCB_4;
                alu_operation = ADD;
                ir_write      = mem_ready;
                pc_en         = mem_ready;
                w_next        = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b     = SRCB_IMM_SH;
                alu_operation = ADD;
                illegal_op    = !w_valid;
                w_next        = !w_valid                           ? FETCH :
                                (opcode == OP_RTYPE)               ? EXEC_R :
                                (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                                (opcode == OP_BEQ)                 ? BRANCH :
                                (opcode == OP_J)                   ? JUMP : EXEC_I;
            end
            EXEC_R: begin
                alu_src_a     = 1'b1;
                alu_operation = w_alu_op;
                w_next        = WB_R;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = FETCH;
            end
            EXEC_I: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                alu_operation = w_alu_op;
                w_next        = WB_I;
            end
            WB_I: begin
                reg_write = 1'b1;
                w_next    = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                alu_operation = ADD;
                w_next        = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                w_next   = mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                w_next    = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_operation = SUB;
                pc_src        = PCSRC_ALUOUT;
                pc_en         = zero;
                w_next        = FETCH;
            end
            JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
                w_next = FETCH;
            end
            default: w_next = IDLE;
        endcase
        // An expired wait abandons the access and restarts with a fresh fetch.
        if (w_expire) w_next = FETCH;
    end

`ifdef MC_CTRL_PERF_EN
    logic w_retire;
    assign w_retire = (r_state == WB_R) || (r_state == WB_I) || (r_state == WB_MEM) ||
                      (r_state == BRANCH) || (r_state == JUMP) || (r_state == MEM_WR && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            retired_cnt <= retired_cnt + 32'(w_retire);
            cycle_cnt   <= cycle_cnt + 32'(r_state != IDLE);
        end
    end
`endif
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: table-driven cycle-by-cycle check of the controller outputs,
// plus hand sequences for watchdog expiry and asynchronous reset.
module tb_mips_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, illegal_op, mem_timeout;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_operation;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired_cnt, cycle_cnt;
`endif

    always #5 clk = ~clk;

    mips_multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_operation(alu_operation),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
`ifdef MC_CTRL_PERF_EN
        , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
    );

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, J = 6'h02;
    localparam logic [5:0] ADDI = 6'h08, SLTI = 6'h0a, BAD = 6'h3f;

    localparam logic [17:0] B_PCE = 18'h20000, B_IO = 18'h10000, B_MR = 18'h08000;
    localparam logic [17:0] B_MW = 18'h04000, B_IRW = 18'h02000, B_M2R = 18'h01000;
    localparam logic [17:0] B_RD = 18'h00800, B_RW = 18'h00400, B_SA = 18'h00200;
    localparam logic [17:0] SB_4 = 18'h00080, SB_IMM = 18'h00100, SB_SH = 18'h00180;
    localparam logic [17:0] PS_OUT = 18'h00020, PS_J = 18'h00040, B_ILL = 18'h2, B_TMO = 18'h1;
    localparam logic [17:0] A_ADD = 18'h4, A_SUB = 18'h8, A_AND = 18'hc, A_OR = 18'h10, A_SLT = 18'h14;

    localparam logic [17:0] F1  = B_PCE | B_MR | B_IRW | SB_4 | A_ADD;
    localparam logic [17:0] F0  = B_MR | SB_4 | A_ADD;
    localparam logic [17:0] DEC = SB_SH | A_ADD;
    localparam logic [17:0] WBR = B_RD | B_RW;
    localparam logic [17:0] WBI = B_RW;
    localparam logic [17:0] MA  = B_SA | SB_IMM | A_ADD;
    localparam logic [17:0] MRD = B_IO | B_MR;
    localparam logic [17:0] WBM = B_M2R | B_RW;
    localparam logic [17:0] MWR = B_IO | B_MW;
    localparam logic [17:0] BR0 = B_SA | PS_OUT | A_SUB;
    localparam logic [17:0] JMP = B_PCE | PS_J;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0, n_err = 0;

    function automatic logic [17:0] obs();
        return {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, pc_src, alu_operation, illegal_op, mem_timeout};
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic r, input logic [17:0] e);
        vecs.push_back('{n, op, fn, z, r, e});
    endtask

    task automatic add_r(input string n, input logic [5:0] fn, input logic [17:0] a);
        add({n, ".fetch"}, R, fn, 1'b0, 1'b1, F1);
        add({n, ".decode"}, R, fn, 1'b0, 1'b1, DEC);
        add({n, ".exec"}, R, fn, 1'b0, 1'b1, B_SA | a);
        add({n, ".wb"}, R, fn, 1'b0, 1'b1, WBR);
    endtask

    task automatic add_i(input string n, input logic [5:0] op, input logic [17:0] a);
        add({n, ".fetch"}, op, 6'h0, 1'b0, 1'b1, F1);
        add({n, ".decode"}, op, 6'h0, 1'b0, 1'b1, DEC);
        add({n, ".exec"}, op, 6'h0, 1'b0, 1'b1, B_SA | SB_IMM | a);
        add({n, ".wb"}, op, 6'h0, 1'b0, 1'b1, WBI);
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic r);
        @(posedge clk);
        #1;
        opcode = op;
        funct = fn;
        zero = z;
        mem_ready = r;
        @(negedge clk);
    endtask

    initial begin
        add_r("add", 6'h20, A_ADD);
        add_r("sub", 6'h22, A_SUB);
        add_r("and", 6'h24, A_AND);
        add_r("or", 6'h25, A_OR);
        add_r("slt", 6'h2a, A_SLT);
        add("lw.fetch", LW, 6'h0, 1'b0, 1'b1, F1);
        add("lw.decode", LW, 6'h0, 1'b0, 1'b1, DEC);
        add("lw.addr", LW, 6'h0, 1'b0, 1'b1, MA);
        for (int i = 0; i < 3; i++) add("lw.rd_stall", LW, 6'h0, 1'b0, 1'b0, MRD);
        add("lw.rd_done", LW, 6'h0, 1'b0, 1'b1, MRD);
        add("lw.wb", LW, 6'h0, 1'b0, 1'b1, WBM);
        add("sw.fetch", SW, 6'h0, 1'b0, 1'b1, F1);
        add("sw.decode", SW, 6'h0, 1'b0, 1'b1, DEC);
        add("sw.addr", SW, 6'h0, 1'b0, 1'b1, MA);
        add("sw.wr", SW, 6'h0, 1'b0, 1'b1, MWR);
        add("beq1.fetch", BEQ, 6'h0, 1'b1, 1'b1, F1);
        add("beq1.decode", BEQ, 6'h0, 1'b1, 1'b1, DEC);
        add("beq1.branch", BEQ, 6'h0, 1'b1, 1'b1, BR0 | B_PCE);
        add("beq0.fetch", BEQ, 6'h0, 1'b0, 1'b1, F1);
        add("beq0.decode", BEQ, 6'h0, 1'b0, 1'b1, DEC);
        add("beq0.branch", BEQ, 6'h0, 1'b0, 1'b1, BR0);
        add("j.fetch", J, 6'h0, 1'b0, 1'b1, F1);
        add("j.decode", J, 6'h0, 1'b0, 1'b1, DEC);
        add("j.jump", J, 6'h0, 1'b0, 1'b1, JMP);
        add("bad.fetch_stall", BAD, 6'h0, 1'b0, 1'b0, F0);
        add("bad.fetch", BAD, 6'h0, 1'b0, 1'b1, F1);
        add("bad.decode", BAD, 6'h0, 1'b0, 1'b1, DEC | B_ILL);
        add("badfn.fetch", R, 6'h00, 1'b0, 1'b1, F1);
        add("badfn.decode", R, 6'h00, 1'b0, 1'b1, DEC | B_ILL);
        add_i("addi", ADDI, A_ADD);
        add_i("slti", SLTI, A_SLT);

        repeat (2) @(negedge clk);
        chk("reset.outputs", obs(), 18'h0);
`ifdef MC_CTRL_PERF_EN
        chk("reset.cycle_cnt", 18'(cycle_cnt), 18'h0);
`endif
        rst_n = 1'b1;
        #1 chk("idle.outputs", obs(), 18'h0);

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
            chk(vecs[i].name, obs(), vecs[i].exp);
        end

        // sw whose write never completes: 15 stalled cycles, then forced refetch
        step(SW, 6'h0, 1'b0, 1'b1); chk("swto.fetch", obs(), F1);
        step(SW, 6'h0, 1'b0, 1'b1); chk("swto.decode", obs(), DEC);
        step(SW, 6'h0, 1'b0, 1'b1); chk("swto.addr", obs(), MA);
        for (int i = 0; i < 15; i++) begin
            step(SW, 6'h0, 1'b0, 1'b0);
            chk("swto.stall", obs(), MWR);
        end
        step(SW, 6'h0, 1'b0, 1'b0); chk("swto.refetch", obs(), F0 | B_TMO);
        step(R, 6'h20, 1'b0, 1'b1); chk("swto.sticky_fetch", obs(), F1 | B_TMO);
        step(R, 6'h20, 1'b0, 1'b1); chk("swto.sticky_decode", obs(), DEC | B_TMO);
        step(R, 6'h20, 1'b0, 1'b1); chk("swto.sticky_exec", obs(), B_SA | A_ADD | B_TMO);
        step(R, 6'h20, 1'b0, 1'b1); chk("swto.sticky_wb", obs(), WBR | B_TMO);
        #1 rst_n = 1'b0;
        #1 chk("swto.reset_clears", obs(), 18'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset asserted in the middle of a load's writeback
        step(LW, 6'h0, 1'b0, 1'b1); chk("lwrst.fetch", obs(), F1);
        step(LW, 6'h0, 1'b0, 1'b1); chk("lwrst.decode", obs(), DEC);
        step(LW, 6'h0, 1'b0, 1'b1); chk("lwrst.addr", obs(), MA);
        step(LW, 6'h0, 1'b0, 1'b1); chk("lwrst.rd", obs(), MRD);
        step(LW, 6'h0, 1'b0, 1'b1); chk("lwrst.wb", obs(), WBM);
        #1 rst_n = 1'b0;
        #1 chk("lwrst.async_zero", obs(), 18'h0);
`ifdef MC_CTRL_PERF_EN
        chk("lwrst.cycle_cnt", 18'(cycle_cnt), 18'h0);
        chk("lwrst.retired_cnt", 18'(retired_cnt), 18'h0);
`endif
        @(posedge clk);
        #1 chk("lwrst.held", obs(), 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("lwrst.idle", obs(), 18'h0);

        // fetch that never completes: watchdog fires and fetch retries
        step(R, 6'h0, 1'b0, 1'b0); chk("fto.first_fetch", obs(), F0);
        for (int i = 0; i < 14; i++) begin
            step(R, 6'h0, 1'b0, 1'b0);
            chk("fto.stall", obs(), F0);
        end
        step(R, 6'h0, 1'b0, 1'b0); chk("fto.retry", obs(), F0 | B_TMO);
        step(R, 6'h20, 1'b0, 1'b1); chk("fto.recover", obs(), F1 | B_TMO);
        step(R, 6'h20, 1'b0, 1'b1); chk("fto.decode", obs(), DEC | B_TMO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
